// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock FIFO built on a register array.
// Data is read out through a register, so it appears one cycle after the read is accepted.
// The empty/full flags are decoded combinationally from the occupancy count.
// Optional feature macro FIFO_OVF_UDF_EN adds the overflow and underflow outputs.
// Each is a 1-cycle registered pulse that flags a rejected write or a rejected read.
module sync_fifo_core #(
    parameter int unsigned FIFO_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  empty,
`ifdef FIFO_OVF_UDF_EN
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
`else
    output logic                  full
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]      count_q,    count_d;
    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_acc;
    logic                  rd_acc;

`ifdef FIFO_OVF_UDF_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;
`endif

    // Flags decode the pre-edge count, so a write never bypasses to a read.
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign data_out = data_out_q;

`ifdef FIFO_OVF_UDF_EN
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    // Acceptance, pointer advance, occupancy and read-data next-state logic.
    always_comb begin
        wr_acc     = wr_en & ~full;
        rd_acc     = rd_en & ~empty;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        count_d    = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            data_out_d = mem_q[rd_ptr_q];
        end
`ifdef FIFO_OVF_UDF_EN
        overflow_d  = wr_en & full;
        underflow_d = rd_en & empty;
`endif
    end

    // Control and read-data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
`ifdef FIFO_OVF_UDF_EN
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
`ifdef FIFO_OVF_UDF_EN
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`endif
        end
    end

    // Storage array: no reset, and it is written only when a write is accepted outside reset.
    always_ff @(posedge clk) begin
        if (rstN && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo_core.sv
// Self-checking bench for sync_fifo_core.
// A queue scoreboard holds the words that have been accepted.
// Each read the model accepts pops the word that is expected on data_out.
module tb_sync_fifo_core;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;

    logic             clk;
    logic             rstN;
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
`ifdef FIFO_OVF_UDF_EN
    logic             overflow;
    logic             underflow;
`endif

    int unsigned      errors = 0;
    int unsigned      checks = 0;
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] last_out;

    sync_fifo_core #(
        .FIFO_WIDTH(WIDTH),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .rd_en    (rd_en),
        .data_out (data_out),
        .empty    (empty),
`ifdef FIFO_OVF_UDF_EN
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
`else
        .full     (full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Hold reset for n edges with the given strobes, checking reset values after each edge.
    task automatic do_reset(input int n, input logic w, input logic [WIDTH-1:0] d, input logic r);
        rstN    = 1'b0;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("rst_empty", 32'(empty), 32'd1);
            check("rst_full", 32'(full), 32'd0);
            check("rst_data_out", 32'(data_out), 32'd0);
`ifdef FIFO_OVF_UDF_EN
            check("rst_overflow", 32'(overflow), 32'd0);
            check("rst_underflow", 32'(underflow), 32'd0);
`endif
        end
        sb.delete();
        last_out = '0;
        rstN  = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Drive one clock of strobes; the model decides acceptance from the pre-edge occupancy.
    task automatic drive_cycle(input logic w, input logic [WIDTH-1:0] d, input logic r);
        bit               pre_full;
        bit               pre_empty;
        bit               wacc;
        bit               racc;
        logic [WIDTH-1:0] exp_out;
        pre_full  = (sb.size() == DEPTH);
        pre_empty = (sb.size() == 0);
        wacc      = w && !pre_full;
        racc      = r && !pre_empty;
        exp_out   = last_out;
        if (racc) exp_out = sb.pop_front();
        if (wacc) sb.push_back(d);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        check("data_out", 32'(data_out), 32'(exp_out));
        last_out = exp_out;
        check("empty", 32'(empty), 32'(sb.size() == 0));
        check("full", 32'(full), 32'(sb.size() == DEPTH));
`ifdef FIFO_OVF_UDF_EN
        check("overflow", 32'(overflow), 32'(w && pre_full));
        check("underflow", 32'(underflow), 32'(r && pre_empty));
`endif
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        rstN     = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        data_in  = '0;
        last_out = '0;

        // Reset held with a pending write; nothing may be stored.
        do_reset(10, 1'b1, 8'hAA, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b1);

        // Fill to full, then attempt one extra write.
        for (int i = 0; i < 16; i++) drive_cycle(1'b1, WIDTH'(i), 1'b0);
        drive_cycle(1'b1, 8'hFF, 1'b0);

        // Drain, then attempt one extra read, which must leave data_out at 0F.
        for (int i = 0; i < 17; i++) drive_cycle(1'b0, 8'h00, 1'b1);
        check("drain_hold", 32'(data_out), 32'h0F);

        // Pointer wrap-around.
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, WIDTH'(8'h20 + i), 1'b0);
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) drive_cycle(1'b1, WIDTH'(8'h40 + i), 1'b0);
        for (int i = 0; i < 12; i++) drive_cycle(1'b0, 8'h00, 1'b1);
        check("wrap_empty", 32'(empty), 32'd1);

        // Simultaneous read and write at count 5, then drain.
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, WIDTH'(8'h60 + i), 1'b0);
        drive_cycle(1'b1, 8'h7E, 1'b1);
        check("simul5_count", 32'(sb.size()), 32'd5);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 8'h00, 1'b1);

        // Simultaneous read and write at empty: only the write is accepted.
        drive_cycle(1'b1, 8'h81, 1'b1);
        check("simul0_empty", 32'(empty), 32'd0);

        // Simultaneous read and write at full: only the read is accepted.
        for (int i = 0; i < 15; i++) drive_cycle(1'b1, WIDTH'(8'h90 + i), 1'b0);
        drive_cycle(1'b1, 8'hEE, 1'b1);
        check("simul16_full", 32'(full), 32'd0);
        for (int i = 0; i < 15; i++) drive_cycle(1'b0, 8'h00, 1'b1);

        // Reset in mid-operation discards the stored data.
        for (int i = 0; i < 7; i++) drive_cycle(1'b1, WIDTH'(8'hB0 + i), 1'b0);
        do_reset(1, 1'b1, 8'hCC, 1'b1);
        drive_cycle(1'b1, 8'h5A, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b1);
        check("post_rst_data", 32'(data_out), 32'h5A);
        drive_cycle(1'b0, 8'h00, 1'b1);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_core.md
Name: sync_fifo_core

Overview:
- Single-clock synchronous FIFO built on a register array.
- Accepts write and read strobes on one clock and reports empty/full status.
- Sits between a producer and a consumer in the same clock domain. It is the DUT of the FIFO testbench, driven through the FIFO interface bundle.

Parameters:
- FIFO_WIDTH, 8: data word width in bits (must be ≥1).
- FIFO_DEPTH, 16: number of storage entries (power of two, ≥2).

Ports:
- clk  input  1  rising-edge clock.
- rstN  input  1  synchronous active-low reset, sampled on posedge clk.
- wr_en  input  1  write request; data_in is written on this edge if the write is accepted.
- data_in  input  FIFO_WIDTH  write data.
- rd_en  input  1  read request.
- data_out  output  FIFO_WIDTH  registered read data.
- empty  output  1  high when the FIFO holds 0 entries.
- full  output  1  high when the FIFO holds FIFO_DEPTH entries.
- overflow  output  1  present only with FIFO_OVF_UDF_EN.
- underflow  output  1  present only with FIFO_OVF_UDF_EN.

Behaviour:
- Reset:
  - On posedge clk with rstN=0: wr_ptr=0, rd_ptr=0, count=0, data_out=0, empty=1, full=0, overflow=0, underflow=0.
  - Storage array contents are not cleared.
  - Reset wins over any simultaneous wr_en/rd_en.
  - Reset mid-operation discards all stored data.
- Internal state:
  - wr_ptr and rd_ptr are each log2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0.
  - count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- Write acceptance: wr_acc = wr_en & ~full.
  - On accept: mem[wr_ptr] <= data_in; wr_ptr increments.
  - Write while full is ignored; memory and pointers are unchanged.
- Read acceptance: rd_acc = rd_en & ~empty.
  - On accept: data_out <= mem[rd_ptr]; rd_ptr increments.
  - Read latency is 1 cycle: data is valid on data_out after the accepting edge.
  - Read while empty is ignored and data_out holds its previous value.
  - data_out also holds whenever no read is accepted.
- Simultaneous wr_acc & rd_acc:
  - Both complete on the same edge; count is unchanged.
  - Write-to-read is never bypassed. At count=0 the write is accepted and the read is rejected (empty=1).
  - At count=FIFO_DEPTH the read is accepted and the write is rejected (full=1). Flags are evaluated from pre-edge state.
- count update: count <= count + wr_acc - rd_acc.
- Flags:
  - empty = (count==0); full = (count==FIFO_DEPTH).
  - Both are combinational decodes of the count register, so they change one edge after the causing write/read.
  - empty and full are never high together.
- Ordering: strict first-in first-out, including across pointer wrap-around.
- No X propagation: outputs are defined from the first reset edge onward.

Optional Feature:
- Macro: FIFO_OVF_UDF_EN.
- When defined:
  - Ports overflow and underflow exist.
  - overflow is a registered 1-cycle pulse, asserted on the edge after wr_en=1 while full=1.
  - underflow is a registered 1-cycle pulse, asserted on the edge after rd_en=1 while empty=1.
  - Both are cleared by reset and are not sticky.
- When undefined: neither port nor its logic exists. Core behaviour is identical.

Test Plan:
1. Reset: hold rstN=0 for 10 clocks with wr_en=1, data_in=8'hAA -> empty=1, full=0, data_out=0; no entry stored after rstN=1.
2. Write-only fill (FIFO_DEPTH=16, FIFO_WIDTH=8): write 8'h00..8'h0F on consecutive clocks -> empty drops after the 1st edge; full rises after the 16th edge; a 17th write of 8'hFF is ignored (with FIFO_OVF_UDF_EN, overflow pulses for 1 cycle).
3. Drain: after case 2, assert rd_en for 16 clocks -> data_out sequence 8'h00..8'h0F, one cycle after each accepting edge; empty=1 after the 16th; a 17th read leaves data_out=8'h0F (underflow pulses if enabled).
4. Wrap-around: write 10, read 10, write 12, read 12 -> data strictly in order across the pointer wrap; count returns to 0.
5. Simultaneous rd/wr:
   - At count=5: count stays 5 and the oldest word appears on data_out.
   - At count=0 (empty): write accepted, read rejected, count=1.
   - At count=16 (full): read accepted, write rejected, count=15.
6. Reset mid-operation: with count=7, assert rstN=0 for one edge -> empty=1, full=0, data_out=0; the next write/read returns the newly written data only.
